// File: rtl/spi_pkg.sv
// Shared constants, FSM encoding and command-word payload for the SPI master.
// Ports: none (package).
package spi_pkg;

  localparam int unsigned WORD_SIZE   = 8;
  localparam int unsigned INPUT_SIZE  = WORD_SIZE + 2;
  localparam int unsigned RD_LATENCY  = 3;
  localparam int unsigned TAIL_CYCLES = 2;
  localparam int unsigned GAP_CYCLES  = 1;
  localparam int unsigned CNT_W       = 5;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CMD,
    ST_SHIFT,
    ST_TAIL,
    ST_WAIT,
    ST_RECV,
    ST_END,
    ST_GAP
  } state_e;

  // Serialised command word, MSB (cmd[1]) goes out first.
  typedef struct packed {
    logic [1:0]           cmd;
    logic [WORD_SIZE-1:0] din;
  } spi_word_t;

  // True on the last cycle of a phase that lasts len cycles.
  function automatic logic last_cycle(input logic [CNT_W-1:0] cnt, input int unsigned len);
    return cnt == CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/spi_master_interface_if.sv
// Host-side handshake bundle of the SPI master.
//   start/cmd/din : frame request from the host
//   busy/done     : frame status back to the host
//   rd_data/rd_valid : captured reply of rd-data frames
// Modports: master = host side, slave = SPI master block side.
interface spi_master_interface_if;
  import spi_pkg::*;

  logic                 start;
  logic [1:0]           cmd;
  logic [WORD_SIZE-1:0] din;
  logic                 busy;
  logic                 done;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 rd_valid;

  modport master (
    output start, cmd, din,
    input  busy, done, rd_data, rd_valid
  );

  modport slave (
    input  start, cmd, din,
    output busy, done, rd_data, rd_valid
  );

endinterface

// File: rtl/spi_shift_reg.sv
// Frame shift register: parallel load, shift left with serial input at the LSB.
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : load load_data (wins over shift)
//   shift       : shift left by one, shift_in enters at the LSB
//   msb         : current MSB (serial output)
//   msb_next    : bit that becomes the MSB after the next shift
//   capture_c   : low CAP_W bits as they will be after the next shift
module spi_shift_reg #(
  parameter int unsigned W     = 10,
  parameter int unsigned CAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [W-1:0]     load_data,
  input  logic             shift_in,
  output logic             msb,
  output logic             msb_next,
  output logic [CAP_W-1:0] capture_c
);

  logic [W-1:0] data_q;

  // Shift/load register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end else if (shift) begin
      data_q <= {data_q[W-2:0], shift_in};
    end
  end

  assign msb       = data_q[W-1];
  assign msb_next  = data_q[W-2];
  assign capture_c = {data_q[CAP_W-2:0], shift_in};

endmodule

// File: rtl/spi_master_interface.sv
// Host-side SPI master: serialises one {cmd,din} word per accepted start on
// MOSI under SS_n framing and, for rd-data frames, captures the 8-bit MISO reply.
// Ports:
//   clk, rst_n      : clock (also the SPI bit clock), synchronous active-low reset
//   bus (slave)     : start/cmd/din in, busy/done/rd_data/rd_valid out
//   SS_n, MOSI      : slave select (active low) and serial data to the slave
//   MISO            : serial reply from the slave
// Build option SPI_MASTER_AUTO_RD_EN: an rd-addr frame is automatically
// followed by an rd-data frame; only the second frame reports done.
module spi_master_interface
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  spi_master_interface_if.slave bus,
  output logic                  SS_n,
  output logic                  MOSI,
  input  logic                  MISO
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [1:0]           cmd_q;
  logic                 chain_c;
  spi_word_t            load_word_c;
  logic                 sr_load_c;
  logic                 sr_shift_c;
  logic                 sr_msb;
  logic                 sr_msb_next;
  logic [WORD_SIZE-1:0] sr_capture_c;
  logic                 ss_n_d;
  logic                 mosi_d;
  logic                 busy_d;
  logic                 done_d;
  logic                 rd_valid_d;
  logic [WORD_SIZE-1:0] rd_data_d;

  // Chain an rd-data frame after an rd-addr frame when the option is built in.
`ifdef SPI_MASTER_AUTO_RD_EN
  assign chain_c = (cmd_q == CMD_RD_ADDR);
`else
  assign chain_c = 1'b0;
`endif

  // Word to load: host request from IDLE, the fixed rd-data word when chaining.
  always_comb begin
    load_word_c.cmd = bus.cmd;
    load_word_c.din = bus.din;
    if (state_q == ST_GAP) begin
      load_word_c.cmd = CMD_RD_DATA;
      load_word_c.din = '0;
    end
  end

  assign sr_load_c  = (state_d == ST_LOAD);
  assign sr_shift_c = (state_q == ST_SHIFT) || (state_q == ST_RECV);

  spi_shift_reg #(
    .W     (INPUT_SIZE),
    .CAP_W (WORD_SIZE)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sr_load_c),
    .shift     (sr_shift_c),
    .load_data (load_word_c),
    .shift_in  (MISO),
    .msb       (sr_msb),
    .msb_next  (sr_msb_next),
    .capture_c (sr_capture_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    ss_n_d     = 1'b1;
    mosi_d     = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = bus.rd_data;

    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_CMD;
      ST_CMD:   state_d = ST_SHIFT;
      ST_SHIFT: if (last_cycle(cnt_q, INPUT_SIZE))
                  state_d = (cmd_q == CMD_RD_DATA) ? ST_WAIT : ST_TAIL;
      ST_TAIL:  if (last_cycle(cnt_q, TAIL_CYCLES)) state_d = ST_END;
      ST_WAIT:  if (last_cycle(cnt_q, RD_LATENCY)) state_d = ST_RECV;
      ST_RECV:  if (last_cycle(cnt_q, WORD_SIZE)) state_d = ST_END;
      ST_END:   state_d = ST_GAP;
      ST_GAP:   if (last_cycle(cnt_q, GAP_CYCLES))
                  state_d = chain_c ? ST_LOAD : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    ss_n_d = !(state_d inside {ST_LOAD, ST_CMD, ST_SHIFT, ST_TAIL, ST_WAIT, ST_RECV});
    busy_d = (state_d != ST_IDLE);

    // F0 repeats the first word bit taken straight from the load word; once
    // shifting is under way the next MSB is the bit below the current one.
    if (state_d == ST_LOAD) begin
      mosi_d = load_word_c.cmd[1];
    end else if (state_d inside {ST_CMD, ST_SHIFT}) begin
      mosi_d = (state_q == ST_SHIFT) ? sr_msb_next : sr_msb;
    end

    done_d     = (state_d == ST_END) && !chain_c;
    rd_valid_d = done_d && (cmd_q == CMD_RD_DATA);
    // The last MISO bit is sampled on the same edge that enters END.
    if (rd_valid_d) rd_data_d = sr_capture_c;
  end

  // Phase counter (restarts on every state change, saturates) and latched command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      cmd_q <= CMD_WR_ADDR;
    end else begin
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_d == ST_LOAD) cmd_q <= load_word_c.cmd;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      SS_n         <= 1'b1;
      MOSI         <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      SS_n         <= ss_n_d;
      MOSI         <= mosi_d;
      bus.busy     <= busy_d;
      bus.done     <= done_d;
      bus.rd_valid <= rd_valid_d;
      bus.rd_data  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_spi_master_interface.sv
// Bench for spi_master_interface: a bit-level SPI slave + RAM model answers
// on MISO, and a frame-level model predicts every output on every cycle.
module tb_spi_master_interface;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ss_n;
  logic mosi;
  logic miso = 1'b0;

  always #5 clk = ~clk;

  spi_master_interface_if bus();

  spi_master_interface dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .SS_n  (ss_n),
    .MOSI  (mosi),
    .MISO  (miso)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- frame-level expectation model ----------------
  typedef struct {
    bit       ss_n;
    bit       mosi;
    bit       busy;
    bit       done;
    bit       rv;
    bit       apply;
    bit [1:0] cmd;
    bit [7:0] din;
  } rec_t;

  rec_t     q[$];
  rec_t     cur;
  rec_t     idle_rec;
  bit       live = 1'b0;
  bit [7:0] m_ram [256];
  bit [7:0] m_wa, m_ra, m_rd;

  function automatic rec_t mk(input bit s, input bit m, input bit d, input bit rv);
    rec_t r;
    r.ss_n = s; r.mosi = m; r.busy = 1'b1; r.done = d; r.rv = rv;
    r.apply = 1'b0; r.cmd = 2'd0; r.din = 8'd0;
    return r;
  endfunction

  // One frame as a list of per-cycle expected outputs.
  task automatic push_frame(input bit [1:0] c, input bit [7:0] d, input bit report);
    bit [9:0] w;
    rec_t     r;
    int       low_extra;
    w = {c, d};
    q.push_back(mk(1'b0, w[9], 1'b0, 1'b0));
    q.push_back(mk(1'b0, w[9], 1'b0, 1'b0));
    for (int i = 9; i >= 0; i--) q.push_back(mk(1'b0, w[i], 1'b0, 1'b0));
    low_extra = (c == 2'd3) ? int'(RD_LATENCY + WORD_SIZE) : int'(TAIL_CYCLES);
    for (int i = 0; i < low_extra; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    r = mk(1'b1, 1'b0, report, report && (c == 2'd3));
    r.apply = 1'b1; r.cmd = c; r.din = d;
    q.push_back(r);
    for (int i = 0; i < int'(GAP_CYCLES); i++) q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic model_accept(input bit [1:0] c, input bit [7:0] d);
`ifdef SPI_MASTER_AUTO_RD_EN
    if (c == 2'd2) begin
      push_frame(c, d, 1'b0);
      push_frame(2'd3, 8'd0, 1'b1);
    end else begin
      push_frame(c, d, 1'b1);
    end
`else
    push_frame(c, d, 1'b1);
`endif
  endtask

  task automatic apply_rec(input rec_t r);
    case (r.cmd)
      2'd0: m_wa = r.din;
      2'd1: m_ram[m_wa] = r.din;
      2'd2: m_ra = r.din;
      default: m_rd = m_ram[m_ra];
    endcase
  endtask

  initial begin
    idle_rec = mk(1'b1, 1'b0, 1'b0, 1'b0);
    idle_rec.busy = 1'b0;
    cur = idle_rec;
  end

  // Compare process: advance the model on each edge, check outputs 1 time unit later.
  always begin
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      cur = idle_rec;
      m_rd = 8'd0;
      live = 1'b1;
    end else begin
      if (bus.start === 1'b1 && !cur.busy) model_accept(bus.cmd, bus.din);
      if (q.size() > 0) cur = q.pop_front();
      else cur = idle_rec;
      if (cur.apply) apply_rec(cur);
    end
    #1;
    if (live) begin
      chk("ss_n",     16'(ss_n),         16'(cur.ss_n));
      chk("mosi",     16'(mosi),         16'(cur.mosi));
      chk("busy",     16'(bus.busy),     16'(cur.busy));
      chk("done",     16'(bus.done),     16'(cur.done));
      chk("rd_valid", 16'(bus.rd_valid), 16'(cur.rv));
      chk("rd_data",  16'(bus.rd_data),  16'(m_rd));
    end
  end

  // ---------------- bit-level SPI slave + RAM ----------------
  int       fc = 0;
  int       frames = 0;
  int       last_len = 0;
  int       done_cnt = 0;
  bit [10:0] mosi_bits;
  bit [9:0] sw;
  bit [1:0] s_cmd;
  bit [7:0] s_ram [256];
  bit [7:0] s_wa, s_ra, s_data;

  always @(negedge clk) begin
    if (ss_n === 1'b0) begin
      if (fc == 0) frames++;
      if (fc >= 1 && fc <= 11) mosi_bits = {mosi_bits[9:0], mosi === 1'b1};
      if (fc >= 2 && fc <= 11) sw = {sw[8:0], mosi === 1'b1};
      if (fc == 11) begin
        s_cmd = sw[9:8];
        case (s_cmd)
          2'd0: s_wa = sw[7:0];
          2'd1: s_ram[s_wa] = sw[7:0];
          2'd2: s_ra = sw[7:0];
          default: s_data = s_ram[s_ra];
        endcase
      end
      if (s_cmd == 2'd3 && fc >= 15 && fc <= 22) miso = s_data[3'(22 - fc)];
      else miso = 1'b0;
      fc++;
    end else begin
      if (fc != 0) last_len = fc;
      fc = 0;
      miso = 1'b0;
    end
    if (bus.done === 1'b1) done_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic run_frame(input logic [1:0] c, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = c; bus.din = d;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("frame_finishes", 16'(ok), 16'd1);
  endtask

  int  f0, d0;
  bit  seen, ended;

  initial begin
    bus.start = 1'b0; bus.cmd = 2'd0; bus.din = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ss_n",    16'(ss_n),        16'd1);
    chk("reset_busy",    16'(bus.busy),    16'd0);
    chk("reset_rd_data", 16'(bus.rd_data), 16'h00);

    // Writes.
    d0 = done_cnt;
    run_frame(CMD_WR_ADDR, 8'h3C);
    chk("wr_addr_len",  16'(last_len),        16'd14);
    chk("wr_addr_mosi", 16'(mosi_bits),       16'b000_0000_0111_1000 >> 1);
    chk("wr_addr_done", 16'(done_cnt - d0),   16'd1);
    d0 = done_cnt;
    run_frame(CMD_WR_DATA, 8'hA5);
    chk("wr_data_len",  16'(last_len),        16'd14);
    chk("wr_data_done", 16'(done_cnt - d0),   16'd1);

    // Read back.
    run_frame(CMD_RD_ADDR, 8'h3C);
    run_frame(CMD_RD_DATA, 8'h00);
    chk("rd_data_a5",  16'(bus.rd_data), 16'hA5);
    chk("rd_frame_len", 16'(last_len),   16'd23);

    // start held high for a whole frame: exactly one frame.
    f0 = frames;
    seen = 1'b0; ended = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = CMD_WR_ADDR; bus.din = 8'h77;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) seen = 1'b1;
      else if (seen) begin
        ended = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_hold_ended",  16'(ended),         16'd1);
    chk("busy_hold_frames", 16'(frames - f0),   16'd1);

    // Boundary addresses and data.
    run_frame(CMD_WR_ADDR, 8'hFF);
    run_frame(CMD_WR_DATA, 8'h00);
    run_frame(CMD_WR_ADDR, 8'h00);
    run_frame(CMD_WR_DATA, 8'hFF);
    run_frame(CMD_RD_ADDR, 8'hFF);
    run_frame(CMD_RD_DATA, 8'h00);
    chk("rd_addr_ff", 16'(bus.rd_data), 16'h00);
    run_frame(CMD_RD_ADDR, 8'h00);
    run_frame(CMD_RD_DATA, 8'h00);
    chk("rd_addr_00", 16'(bus.rd_data), 16'hFF);

`ifdef SPI_MASTER_AUTO_RD_EN
    // One rd-addr start yields two frames and a single done.
    f0 = frames; d0 = done_cnt;
    run_frame(CMD_RD_ADDR, 8'h3C);
    chk("auto_frames",  16'(frames - f0),   16'd2);
    chk("auto_done",    16'(done_cnt - d0), 16'd1);
    chk("auto_rd_data", 16'(bus.rd_data),   16'hA5);
`endif

    // Reset in the middle of SHIFT aborts the frame.
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = CMD_WR_DATA; bus.din = 8'hEE;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ss_n", 16'(ss_n), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 16'(done_cnt - d0), 16'd0);
    chk("abort_rd_data", 16'(bus.rd_data),   16'h00);
    run_frame(CMD_RD_ADDR, 8'h00);
    run_frame(CMD_RD_DATA, 8'h00);
    chk("after_abort_rd", 16'(bus.rd_data), 16'hFF);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
